// File: rtl/host_link_ctrl.sv
// Host-side link to the conv accelerator: streams 3-word beats over con_1..3 and captures chip output into ext-memory writes.
// Capture latency 1 cycle; a beat stays held while con_ready=0 or driving_cons=1. HOST_CHECKSUM_EN adds a running checksum port.
module host_link_ctrl #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  localparam int AW  = $clog2(EXT_MEM_HEIGHT),
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW  = $clog2(OUTPUT_NB_CHANNELS),
  localparam int IOW = IO_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              go,
  input  logic [AW-1:0]     send_len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [3*IOW-1:0]  rd_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [3*IOW-1:0]  wr_data,
  inout  wire  [IOW-1:0]    con_1,
  inout  wire  [IOW-1:0]    con_2,
  inout  wire  [IOW-1:0]    con_3,
  output logic              con_valid,
  input  logic              con_ready,
  input  logic              output_valid,
  input  logic [XW-1:0]     output_x,
  input  logic [YW-1:0]     output_y,
  input  logic [CW-1:0]     output_ch,
  output logic              start,
  input  logic              running,
  input  logic              driving_cons
`ifdef HOST_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    len_q, sent_q;
  logic [3*IOW-1:0] hold;
  logic             hold_vld, rd_inflight, seen_run;
  logic [16:0]      tmo_cnt;
  logic             drive_en, xfer, rd_issue, cap, go_acc;
  logic [AW-1:0]    addr_c;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    rd_issue  = 1'b0;
    drive_en  = (state == S_STREAM) && hold_vld && !driving_cons;
    xfer      = drive_en && con_ready;
    case (state)
      S_IDLE:   if (go) state_nxt = S_START;
      S_START: begin
        start     = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        // Only one read outstanding; the hold slot must be free by the time data lands.
        rd_issue = (!hold_vld || xfer) && !rd_inflight && (rd_addr < len_q);
        if (sent_q == len_q) state_nxt = S_WAIT_RUN;
      end
      S_WAIT_RUN: begin
        if ((seen_run && !running) || (!seen_run && tmo_cnt[16])) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign go_acc    = (state == S_IDLE) && go;
  assign cap       = (state != S_IDLE) && output_valid && driving_cons;
  assign rd_en     = rd_issue;
  assign con_valid = drive_en;
  assign busy      = (state != S_IDLE);

  assign con_1 = drive_en ? hold[IOW-1:0]       : 'z;
  assign con_2 = drive_en ? hold[2*IOW-1:IOW]   : 'z;
  assign con_3 = drive_en ? hold[3*IOW-1:2*IOW] : 'z;

  // Low AW bits of the mod-2^AW product equal the truncated wider product.
  always_comb begin
    addr_c = (AW'(output_ch) * AW'(FEATURE_MAP_HEIGHT) + AW'(output_y))
             * AW'(FEATURE_MAP_WIDTH) + AW'(output_x);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state       <= S_IDLE;
      len_q       <= '0;
      sent_q      <= '0;
      rd_addr     <= '0;
      hold        <= '0;
      hold_vld    <= 1'b0;
      rd_inflight <= 1'b0;
      seen_run    <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (go_acc) begin
        len_q       <= send_len;
        sent_q      <= '0;
        rd_addr     <= '0;
        hold_vld    <= 1'b0;
        rd_inflight <= 1'b0;
        seen_run    <= 1'b0;
        tmo_cnt     <= '0;
      end else begin
        if (running && busy) seen_run <= 1'b1;
        if (busy && !tmo_cnt[16]) tmo_cnt <= tmo_cnt + 17'd1;
        rd_inflight <= rd_issue;
        if (rd_issue) rd_addr <= rd_addr + AW'(1);
        if (rd_inflight) begin
          hold     <= rd_data;
          hold_vld <= 1'b1;
        end else if (xfer) begin
          hold_vld <= 1'b0;
        end
        if (xfer) sent_q <= sent_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= cap;
      if (cap) begin
        wr_data <= {con_3, con_2, con_1};
        wr_addr <= addr_c;
      end
    end
  end

`ifdef HOST_CHECKSUM_EN
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      checksum <= '0;
    end else if (go_acc) begin
      checksum <= '0;
    end else if (cap) begin
      checksum <= checksum + 32'(con_1) + 32'(con_2) + 32'(con_3);
    end
  end
`endif

endmodule
